// File: rtl/reg_file_writeback_if.sv
// Writeback bus: ALU and load result streams in, register-file write port
// and hazard pending queries out.
interface reg_file_writeback_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_reg;
  logic [DW-1:0] mem_data;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] chk_reg_1;
  logic [AW-1:0] chk_reg_2;
  logic          pending_1;
  logic          pending_2;

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  chk_reg_1, chk_reg_2,
    output alu_ready, mem_ready,
    output wr_en, wr_reg, wr_data,
    output pending_1, pending_2
  );

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output chk_reg_1, chk_reg_2,
    input  alu_ready, mem_ready,
    input  wr_en, wr_reg, wr_data,
    input  pending_1, pending_2
  );
endinterface

// File: rtl/reg_file_writeback.sv
// Register-file write initiator: merges ALU and buffered load results into
// one registered write per cycle, with pending-write hazard queries.
module reg_file_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_file_writeback_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_fifo_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_reg;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic          w_full;
  logic          w_empty;
  logic          w_alu_fire;
  logic          w_mem_fire;
  logic          w_enq;
  logic          w_deq;
  logic          w_alu_wr;
  logic [PW-1:0] w_off;
  logic          w_hit_1;
  logic          w_hit_2;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  assign wb.alu_ready = rst_n & ~w_full;
  assign wb.mem_ready = rst_n & ~w_full;

  assign w_alu_fire = wb.alu_valid & wb.alu_ready;
  assign w_mem_fire = wb.mem_valid & wb.mem_ready;
  assign w_enq      = w_mem_fire & (wb.mem_reg != '0);
  assign w_alu_wr   = w_alu_fire & (wb.alu_reg != '0);

  // Head wins when full or ALU idle; exclusive with an ALU grant by construction.
  assign w_deq = ~w_empty & (w_full | ~wb.alu_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_enq) begin
        r_fifo_reg[r_wr_ptr]  <= wb.mem_reg;
        r_fifo_data[r_wr_ptr] <= wb.mem_data;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      r_wr_en <= w_deq | w_alu_wr;
      if (w_deq) begin
        r_wr_reg  <= r_fifo_reg[r_rd_ptr];
        r_wr_data <= r_fifo_data[r_rd_ptr];
      end else if (w_alu_wr) begin
        r_wr_reg  <= wb.alu_reg;
        r_wr_data <= wb.alu_data;
      end
    end
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    w_off   = '0;
    w_hit_1 = r_wr_en & (r_wr_reg == wb.chk_reg_1);
    w_hit_2 = r_wr_en & (r_wr_reg == wb.chk_reg_2);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if (CW'(w_off) < r_count) begin
        if (r_fifo_reg[i] == wb.chk_reg_1) w_hit_1 = 1'b1;
        if (r_fifo_reg[i] == wb.chk_reg_2) w_hit_2 = 1'b1;
      end
    end
  end

  assign wb.pending_1 = (wb.chk_reg_1 != '0) & w_hit_1;
  assign wb.pending_2 = (wb.chk_reg_2 != '0) & w_hit_2;

  assign wb.wr_en   = r_wr_en;
  assign wb.wr_reg  = r_wr_reg;
  assign wb.wr_data = r_wr_data;
endmodule

// File: doc/reg_file_writeback.md
Name: reg_file_writeback

Overview:
- Write-side initiator for register_file's single write port (wr_en/wr_reg/wr_data). Sits between the execute stage (ALU results) and the load unit (memory results) and the register file.
- Merges both writeback streams via valid/ready handshakes and buffers load results in a small FIFO.
- Issues at most one register write per cycle.
- Exposes a pending-write query that hazard logic uses to stall reads of registers with in-flight writes.

Parameters:
- DATA_WIDTH, 32, width of writeback data.
- ADDR_WIDTH, 5, register index width (32 registers, x0 hardwired zero).
- FIFO_DEPTH, 4, load-result buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready.
- alu_reg  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted when mem_valid & mem_ready.
- mem_reg  in  ADDR_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- wr_en  out  1  register_file write enable.
- wr_reg  out  ADDR_WIDTH  register_file write index.
- wr_data  out  DATA_WIDTH  register_file write data.
- chk_reg_1  in  ADDR_WIDTH  hazard query index 1.
- chk_reg_2  in  ADDR_WIDTH  hazard query index 2.
- pending_1  out  1  chk_reg_1 has an in-flight write.
- pending_2  out  1  chk_reg_2 has an in-flight write.

Behaviour:
- Reset (rst_n low at posedge):
  - wr_en=0, wr_reg=0, wr_data=0.
  - FIFO emptied: count=0, read/write pointers=0.
  - All in-flight state cleared.
  - While rst_n is low, alu_ready=0 and mem_ready=0.
  - Reset mid-operation discards buffered entries; no write is issued for them.
- Handshake:
  - A transfer occurs on a posedge where valid & ready.
  - valid must not depend on ready. Sources hold reg/data stable while valid & !ready.
- mem path:
  - mem_ready = !full (count==FIFO_DEPTH means full); no same-cycle dequeue bypass.
  - An accepted mem transfer with mem_reg!=0 enqueues at the tail.
  - mem_reg==0 is accepted and discarded (never enqueued).
- Arbitration (one grant per cycle):
  - FIFO head wins if FIFO is full, or if FIFO is non-empty and alu_valid=0.
  - Otherwise the ALU wins when alu_valid=1.
  - alu_ready = rst_n & !full, combinational.
  - ALU transfer with alu_reg==0: handshake completes, no write issued.
- Output stage (registered, one stage):
  - On the grant edge, wr_en=1, wr_reg/wr_data = the winner's values.
  - With no grant (or an x0 drop), wr_en=0 next cycle; wr_reg/wr_data hold their last values.
  - wr_en is high for exactly one cycle per issued write. Consecutive writes issue back-to-back with no bubble.
- Latency:
  - ALU: accepted at edge N -> wr_en high from N to N+1; register_file captures at edge N+1.
  - mem: enqueued at edge N -> earliest issue at edge N+1 -> register_file captures at N+2.
- FIFO:
  - Enqueue and dequeue in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH, never overflows or underflows.
  - Entries issue in arrival order.
- Pending query (combinational):
  - pending_k = (chk_reg_k!=0) & (chk_reg_k matches any valid FIFO entry, or wr_en & wr_reg==chk_reg_k).
  - chk_reg_k==0 always gives 0.
- Cross-source write ordering is not reordered: the issuing stage must stall on pending before sending a younger ALU write to the same register.

Test Plan:
- Reset, then ALU x5=0xDEADBEEF for 1 cycle -> alu_ready=1, wr_en=1 with wr_reg=5, wr_data=0xDEADBEEF exactly one cycle later; register_file x5 reads 0xDEADBEEF afterward.
- Load x7=0x12345678 with alu_valid=0 -> pending for chk_reg_1=7 is 1 the cycle after accept; wr_en/wr_reg=7 the following cycle; pending drops to 0 after wr_en falls.
- ALU continuously valid (x1..x8) while 4 loads arrive (x10..x13) -> mem_ready=0 once count=4; alu_ready=0 while full; FIFO head issues; writes x10..x13 in order; no write lost or duplicated.
- ALU write to x0 and load to x0 -> both handshakes complete; wr_en stays 0; FIFO count stays 0; pending_1 with chk_reg_1=0 is 0.
- Fill FIFO with 3 loads, assert rst_n=0 for one edge -> wr_en=0, mem_ready=alu_ready=0 during reset, FIFO empty after; none of the 3 writes appears.
- 1000 random cycles of random valid/reg/data on both sources -> every accepted non-x0 transfer appears exactly once on wr_en; per-source order preserved; count never exceeds 4.
